// File: rtl/fir_coef_scheduler_pkg.sv
// fir_cfg_pkg: shared constants, state enum and decode helpers
// for the FIR coefficient scheduler (address map, CTRL bits).
package fir_cfg_pkg;

   localparam int CW_DEF = 8;

   localparam logic [2:0] ADDR_CTRL = 3'd6;
   localparam logic [2:0] ADDR_TAPS = 3'd7;

   localparam int COMMIT  = 0;
   localparam int CLR_OVR = 7;

   typedef enum logic [1:0] {
      IDLE,
      PENDING,
      APPLY
   } state_e;

   // Address targets the shadow bank (coefficient or tap count)
   function automatic logic is_shadow(
      input logic [2:0] a,
      input int         n
   );
      return (int'(a) < n) || (a == ADDR_TAPS);
   endfunction

   // Out-of-range tap counts fall back to the full filter length
   function automatic logic [2:0] clamp_taps(
      input logic [7:0] v,
      input int         n
   );
      if (v == 8'd0 || int'(v) > n)
         return 3'(n);
      return v[2:0];
   endfunction

endpackage

// File: rtl/fir_coef_scheduler_if.sv
// Config write port from config_passer.
// master drives WrEn/RegAddr/D7_D0; slave (scheduler) receives.
interface fir_coef_scheduler_if;

   logic       WrEn;
   logic [2:0] RegAddr;
   logic [7:0] D7_D0;

   modport master (
      output WrEn,
      output RegAddr,
      output D7_D0
   );

   modport slave (
      input WrEn,
      input RegAddr,
      input D7_D0
   );

endinterface

// File: rtl/fir_coef_scheduler_bank.sv
// fir_coef_bank: shadow and active coefficient/tap registers.
// wr_i = accepted shadow write; copy_i = shadow -> active transfer.
module fir_coef_bank
   import fir_cfg_pkg::*;
#(
   parameter int NTAPS = 6,
   parameter int CW    = CW_DEF
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                wr_i,
   input  logic [2:0]          addr_i,
   input  logic [7:0]          data_i,
   input  logic                copy_i,
   output logic [NTAPS*CW-1:0] coef_o,
   output logic [2:0]          taps_o
);

   logic [CW-1:0] sh_q   [NTAPS];
   logic [CW-1:0] sh_d   [NTAPS];
   logic [CW-1:0] act_q  [NTAPS];
   logic [CW-1:0] act_d  [NTAPS];
   logic [2:0]    shtaps_q, shtaps_d;
   logic [2:0]    acttaps_q, acttaps_d;

   always_comb begin
      sh_d      = sh_q;
      act_d     = act_q;
      shtaps_d  = shtaps_q;
      acttaps_d = acttaps_q;
      if (wr_i) begin
         for (int i = 0; i < NTAPS; i++)
            if (int'(addr_i) == i)
               sh_d[i] = CW'(data_i);
         if (addr_i == ADDR_TAPS)
            shtaps_d = clamp_taps(data_i, NTAPS);
      end
      if (copy_i) begin
         act_d     = sh_q;
         acttaps_d = shtaps_q;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NTAPS; i++) begin
            sh_q[i]  <= '0;
            act_q[i] <= '0;
         end
         shtaps_q  <= 3'(NTAPS);
         acttaps_q <= 3'(NTAPS);
      end else begin
         sh_q      <= sh_d;
         act_q     <= act_d;
         shtaps_q  <= shtaps_d;
         acttaps_q <= acttaps_d;
      end
   end

   for (genvar g = 0; g < NTAPS; g++) begin : g_bus
      assign coef_o[g*CW +: CW] = act_q[g];
   end

   assign taps_o = acttaps_q;

endmodule

// File: rtl/fir_coef_scheduler.sv
// fir_coef_scheduler: commits shadow coefficients at a sample boundary.
// Ports: CLK, RST, cfg (write port), SampleStrobe, CoefBus, ActiveTaps,
// CoefValid, Busy, Overrun; TimeoutFlag with COEF_COMMIT_TIMEOUT_EN.
module fir_coef_scheduler
   import fir_cfg_pkg::*;
#(
   parameter int NTAPS = 6,
   parameter int CW    = CW_DEF
`ifdef COEF_COMMIT_TIMEOUT_EN
   ,
   parameter int TIMEOUT = 1024
`endif
) (
   input  logic                  CLK,
   input  logic                  RST,
   fir_coef_scheduler_if.slave   cfg,
   input  logic                  SampleStrobe,
   output logic [NTAPS*CW-1:0]   CoefBus,
   output logic [2:0]            ActiveTaps,
   output logic                  CoefValid,
   output logic                  Busy,
   output logic                  Overrun
`ifdef COEF_COMMIT_TIMEOUT_EN
   ,
   output logic                  TimeoutFlag
`endif
);

   state_e state_q, state_d;
   logic   ovr_q, ovr_d;
   logic   copy;
   logic   go;
   logic   ctrl_wr, commit_wr, clr_wr, sh_wr;

   assign ctrl_wr   = cfg.WrEn && (cfg.RegAddr == ADDR_CTRL);
   assign commit_wr = ctrl_wr && cfg.D7_D0[COMMIT];
   assign clr_wr    = ctrl_wr && cfg.D7_D0[CLR_OVR];
   assign sh_wr     = cfg.WrEn && is_shadow(cfg.RegAddr, NTAPS);

`ifdef COEF_COMMIT_TIMEOUT_EN
   logic [15:0] cnt_q, cnt_d;
   logic        tmo;
   logic        tflag_q, tflag_d;

   assign tmo = (state_q == PENDING) && (cnt_q == 16'(TIMEOUT - 1));
   assign go  = SampleStrobe || tmo;

   always_comb begin
      cnt_d   = '0;
      tflag_d = tflag_q;
      if (state_q == PENDING)
         cnt_d = cnt_q + 16'd1;
      if (clr_wr)
         tflag_d = 1'b0;
      if (tmo && !SampleStrobe)
         tflag_d = 1'b1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q   <= '0;
         tflag_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         tflag_q <= tflag_d;
      end
   end

   assign TimeoutFlag = tflag_q;
`else
   assign go = SampleStrobe;
`endif

   always_comb begin
      state_d = state_q;
      copy    = 1'b0;
      ovr_d   = ovr_q;
      unique case (state_q)
         IDLE:    if (commit_wr) state_d = PENDING;
         PENDING: if (go) begin
            state_d = APPLY;
            copy    = 1'b1;
         end
         APPLY:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Clear and drop cannot share a cycle: one write per cycle
      if (clr_wr)
         ovr_d = 1'b0;
      else if (sh_wr && state_q != IDLE)
         ovr_d = 1'b1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ovr_q   <= ovr_d;
      end
   end

   fir_coef_bank #(
      .NTAPS (NTAPS),
      .CW    (CW)
   ) u_bank (
      .clk_i  (CLK),
      .rst_i  (RST),
      .wr_i   (sh_wr && state_q == IDLE),
      .addr_i (cfg.RegAddr),
      .data_i (cfg.D7_D0),
      .copy_i (copy),
      .coef_o (CoefBus),
      .taps_o (ActiveTaps)
   );

   assign Busy      = (state_q != IDLE);
   assign CoefValid = (state_q == APPLY);
   assign Overrun   = ovr_q;

endmodule
